// File: rtl/cache_fill_if.sv
// Miss-handler bus: cache miss request, main-memory read/return path and cache array writes.
// Modport slave belongs to the fill FSM; modport master is the surrounding cache/memory side.
interface cache_fill_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_address;
    logic [15:0] cache_data;

    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_read_en, memory_address,
               write_data_array, write_tag_array, cache_address, cache_data
    );

    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_read_en, memory_address,
               write_data_array, write_tag_array, cache_address, cache_data
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one 8-word block from pipelined memory into the data array,
// then writes the tag. Handshake: mem_read_en is a one-cycle request with no ready; each
// memory_data_valid carries the oldest outstanding word and is consumed in that same cycle.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_fill_if.slave bus,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_e;

    localparam logic [3:0] N_WORDS   = 4'(WORDS_PER_BLOCK);
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

    state_e      state;
    logic [15:0] base;
    logic [3:0]  issue_cnt;
    logic [3:0]  recv_cnt;
    logic [3:0]  issue_nxt;
    logic        busy_q;
    logic        rd_en_q;
    logic        tag_q;
    logic [15:0] mem_addr_q;

    assign issue_nxt = issue_cnt + 4'd1;

    // Read-side outputs are registered as next-cycle values so the first read leaves
    // in the cycle right after the miss is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= 16'h0000;
            issue_cnt  <= 4'd0;
            recv_cnt   <= 4'd0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            tag_q      <= 1'b0;
            mem_addr_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        state      <= FILL;
                        base       <= bus.miss_address & 16'hFFF0;
                        issue_cnt  <= 4'd0;
                        recv_cnt   <= 4'd0;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        mem_addr_q <= bus.miss_address & 16'hFFF0;
                    end
                end
                FILL: begin
                    if (rd_en_q) begin
                        issue_cnt  <= issue_nxt;
                        rd_en_q    <= (issue_nxt < N_WORDS);
                        // Offset wraps to zero once all reads are out, leaving the base.
                        mem_addr_q <= {base[15:4], issue_nxt[2:0], 1'b0};
                    end
                    if (bus.memory_data_valid) begin
                        recv_cnt <= recv_cnt + 4'd1;
                        if (recv_cnt == LAST_WORD) begin
                            state      <= TAG;
                            tag_q      <= 1'b1;
                            rd_en_q    <= 1'b0;
                            mem_addr_q <= base;
                        end
                    end
                end
                TAG: begin
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                    tag_q      <= 1'b0;
                    mem_addr_q <= 16'h0000;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fsm_busy        = busy_q;
    assign bus.mem_read_en     = rd_en_q;
    assign bus.memory_address  = mem_addr_q;
    assign bus.write_tag_array = tag_q;
    assign fsm_state           = state;

    // Returned words go straight into the data array in the cycle they arrive.
    always_comb begin
        bus.write_data_array = 1'b0;
        bus.cache_data       = 16'h0000;
        bus.cache_address    = 16'h0000;
        case (state)
            FILL: begin
                bus.cache_address = {base[15:4], recv_cnt[2:0], 1'b0};
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.cache_data       = bus.memory_data;
                end
            end
            TAG: begin
                bus.cache_address = base;
            end
            default: begin
                bus.cache_address = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: fixed-latency pipelined memory model plus scoreboard queues
// for expected reads, data-array writes and tag writes.
module tb_cache_fill_fsm;

  localparam int MEM_LATENCY = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] fsm_state;

  cache_fill_if bus ();

  cache_fill_fsm #(.WORDS_PER_BLOCK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // Scoreboard
  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];
  logic [15:0] exp_tag_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Memory model / measurement state
  int          mem_cyc_q[$];
  logic [15:0] mem_addr_q[$];
  logic [15:0] data_base = 16'h0000;
  bit          bubble = 1'b0;
  int          cyc = 0;
  int          fill_start = 0;
  int          busy_cycles = 0;
  int          tag_rel = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic flush_expected();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic push_fill(input logic [15:0] addr, input logic [15:0] dbase);
    logic [15:0] blk;
    blk = {addr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      exp_rd_q.push_back(blk + 16'(2 * i));
      exp_wr_q.push_back({blk + 16'(2 * i), dbase + 16'(i)});
    end
    exp_tag_q.push_back(blk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {27'd0, bus.fsm_busy, bus.mem_read_en, bus.write_data_array,
                           bus.write_tag_array, 1'b0}, 32'd0);
    check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    check({tag, "_addr"}, {bus.memory_address, bus.cache_address}, 32'd0);
    check({tag, "_data"}, {16'd0, bus.cache_data}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the fill.
  task automatic do_fill(input logic [15:0] addr, input logic [15:0] dbase, input bit bub,
                         input bit hold, input int exp_busy, input string name);
    bit done;
    data_base   = dbase;
    bubble      = bub;
    push_fill(addr, dbase);
    fill_start  = cyc;
    busy_cycles = 0;
    tag_rel     = -1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (!hold) begin
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'($urandom);
      end else if (bus.write_tag_array) begin
        bus.miss_detected = 1'b0;
      end
      if (!bus.fsm_busy && exp_rd_q.size() == 0 && exp_wr_q.size() == 0 &&
          exp_tag_q.size() == 0)
        done = 1'b1;
    end
    bus.miss_detected = 1'b0;
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_busy_cycles"}, busy_cycles, exp_busy);
    check({name, "_tag_cycle"}, tag_rel, exp_busy);
    if (!done) flush_expected();
  endtask

  // Memory model and output monitor: drive returns at posedge+1, sample at posedge+2.
  initial begin : mem_monitor
    logic [15:0] a;
    bit prev_valid;
    prev_valid = 1'b0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        mem_cyc_q.delete();
        mem_addr_q.delete();
        bus.memory_data_valid = 1'b0;
        prev_valid = 1'b0;
      end else if (mem_cyc_q.size() > 0 && mem_cyc_q[0] + MEM_LATENCY <= cyc &&
                   !(bubble && prev_valid)) begin
        a = mem_addr_q.pop_front();
        void'(mem_cyc_q.pop_front());
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = data_base + {13'd0, a[3:1]};
        prev_valid = 1'b1;
      end else begin
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'($urandom);
        prev_valid = 1'b0;
      end
      #1;
      if (rst_n) begin
        if (bus.fsm_busy) busy_cycles++;
        if (bus.mem_read_en) begin
          mem_cyc_q.push_back(cyc);
          mem_addr_q.push_back(bus.memory_address);
          if (exp_rd_q.size() == 0) check("rd_unexpected", {16'd0, bus.memory_address}, 32'hDEAD_0000);
          else check("rd_addr", {16'd0, bus.memory_address}, {16'd0, exp_rd_q.pop_front()});
        end
        if (bus.write_data_array) begin
          if (exp_wr_q.size() == 0) check("wr_unexpected", {bus.cache_address, bus.cache_data}, 32'hDEAD_0001);
          else check("wr_addr_data", {bus.cache_address, bus.cache_data}, exp_wr_q.pop_front());
        end
        if (bus.write_tag_array) begin
          tag_rel = cyc - fill_start;
          if (exp_tag_q.size() == 0) check("tag_unexpected", {16'd0, bus.cache_address}, 32'hDEAD_0002);
          else check("tag_addr", {16'd0, bus.cache_address}, {16'd0, exp_tag_q.pop_front()});
        end
        if (!bus.fsm_busy) begin
          check("idle_ctrl", {11'd0, bus.mem_read_en, bus.write_data_array, bus.write_tag_array,
                              fsm_state, bus.cache_data}, 32'd0);
          check("idle_addr", {bus.memory_address, bus.cache_address}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;

    // Reset and idle with no miss
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Basic fill, exact latency
    do_fill(16'h1234, 16'hA000, 1'b0, 1'b0, 13, "basic");
    repeat (3) @(negedge clk);

    // Miss held high through the fill
    do_fill(16'h0ABC, 16'hC000, 1'b0, 1'b1, 13, "held_miss");
    repeat (6) @(negedge clk);

    // Bubbles between returned words
    do_fill(16'h4C62, 16'hB000, 1'b1, 1'b0, 20, "bubbles");
    bubble = 1'b0;
    repeat (3) @(negedge clk);

    // Reset at cycle 7 of a fill, then a fresh fill
    data_base = 16'h5000;
    push_fill(16'h5A5A, 16'h5000);
    fill_start = cyc;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h5A5A;
    @(negedge clk);
    bus.miss_detected = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_cycle", cyc - fill_start, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    flush_expected();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_fill(16'hF80E, 16'h7700, 1'b0, 1'b0, 13, "after_reset");

    // Back-to-back fills, top of address space
    do_fill(16'h0000, 16'h1100, 1'b0, 1'b0, 13, "b2b_low");
    do_fill(16'hFFFE, 16'h2200, 1'b0, 1'b0, 13, "b2b_high");
    repeat (4) @(negedge clk);

    check("queues_empty", exp_rd_q.size() + exp_wr_q.size() + exp_tag_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
